rx_frame_ctrl: RTL
==================

# rx_frame_ctrl

Receive-side controller placed beside the UART receiver top. It owns the receiver's `BaudRate`/`ParityType` configuration, deferring changes until the line is idle. It captures each completed frame (`DoneFlag`/`ErrorFlag`/`Data`) into a small first-word-fall-through (FWFT) queue with a valid/ready consumer handshake. It also keeps sticky overrun and saturating error statistics.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `ERR_CNT_W`, 8: error counter width.
- `IDLE_CYCLES`, 16: consecutive high `RxLine` clocks that declare the line idle.
- `RST_BAUD`, 2'b00: `BaudRate` value after reset.
- `RST_PARITY`, 2'b00: `ParityType` value after reset.

Ports:
- `Clock` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `RxLine` in 1: serial line (same net as receiver `DataTx`), already synchronous to `Clock`.
- `RxDone` in 1: receiver `DoneFlag`.
- `RxError` in 1: receiver `ErrorFlag`.
- `RxData` in 8: receiver `Data`.
- `BaudRate` out 2: drives the receiver.
- `ParityType` out 2: drives the receiver.
- `CfgWrite` in 1: one-cycle strobe requesting a new configuration.
- `CfgBaud` in 2: requested baud rate.
- `CfgParity` in 2: requested parity type.
- `CfgBusy` out 1: a configuration is pending and not yet applied.
- `OutValid` out 1: queue head is valid.
- `OutReady` in 1: consumer accepts the head.
- `OutData` out 8: head data byte.
- `OutErr` out 1: head frame had a parity error.
- `ClearStatus` in 1: clears `ErrCount` and `Overrun`.
- `ErrCount` out `ERR_CNT_W`: saturating count of errored frames.
- `Overrun` out 1: sticky; a frame was dropped because the queue was full.

## Operation
- Line FSM states:
  - `IDLE` → `ACTIVE` when `RxLine`=0.
  - `ACTIVE` → `IDLE` when `RxLine` has been 1 for `IDLE_CYCLES` consecutive clocks; the run counter resets on any 0.
  - `IDLE` → `APPLY` when a configuration is pending and `RxLine`=1.
  - `APPLY` → `IDLE` unconditionally after one cycle.
- Reset state is `IDLE`.
- Configuration:
  - `CfgWrite` loads the pending registers and sets `CfgBusy`.
  - A write while busy overwrites the pending values; last write wins.
  - In `APPLY`, pending values are copied to `BaudRate`/`ParityType` and `CfgBusy` clears.
  - Outputs never change while the FSM is in `ACTIVE`.
- Capture:
  - A rising edge of `RxDone` (current 1, registered previous 0) is a capture event.
  - Only one event per `RxDone` pulse, regardless of pulse width.
- Push:
  - Each capture pushes {`RxError`, `RxData`}.
  - If the queue is full and no pop occurs that cycle, the frame is dropped and `Overrun` is set.
  - Push and pop in the same cycle on a full queue: both succeed and the count is unchanged.
- Pop: occurs when `OutValid`&&`OutReady`. `OutData`/`OutErr` show the head entry combinationally from storage.
- `ErrCount`:
  - Increments on every capture with `RxError`=1, including dropped frames.
  - Saturates at all-ones.
- `ClearStatus` zeroes both statistics. If an event coincides, the event wins: `ErrCount`=1 and/or `Overrun`=1.
- Reset values: `OutValid`=0, `OutData`=0, `OutErr`=0, `ErrCount`=0, `Overrun`=0, `CfgBusy`=0, `BaudRate`=`RST_BAUD`, `ParityType`=`RST_PARITY`. Queue pointers are zero, the run counter is zero, and the `RxDone` history register is 1, so a high level at reset exit is not an event.
- Reset asserted mid-frame or mid-`APPLY`: the queue is flushed, any pending configuration is discarded, and no partial apply occurs.

## Timing
- Capture latency: `RxDone` sampled high at edge k (low at k-1) → entry written at edge k → `OutValid`=1 in the cycle after k.
- Pop: the head advances at the edge where `OutValid`&&`OutReady`. Back-to-back pops sustain one per cycle.
- Config: `CfgWrite` at edge k with FSM in `IDLE` and `RxLine`=1 → `APPLY` after edge k+1 → new `BaudRate`/`ParityType` and `CfgBusy`=0 after edge k+2.
- Idle declaration: the `IDLE_CYCLES`-th consecutive high sample moves `ACTIVE`→`IDLE` at that edge.
- Queue pointers wrap modulo `DEPTH`. Full/empty are distinguished by an extra pointer bit.

## Configuration
- `RXCTRL_ERR_DROP_EN`:
  - Defined: frames with `RxError`=1 are counted but never pushed, and cannot cause `Overrun`. `OutErr` is tied to 0.
  - Undefined: errored frames are queued with `OutErr`=1.

## Structure
- Package `rx_ctrl_pkg`:
  - FSM state enum (`IDLE`, `ACTIVE`, `APPLY`).
  - Baud and parity encoding constants.
  - The 9-bit queue entry type.
- Sub-module `rx_ctrl_fifo`: the FWFT queue, parameterised by `DEPTH`, providing push, pop, full, empty and head.
- Top: FSM, config registers, edge detect and statistics.

## Test plan
- Reset, then three `RxDone` pulses with `RxData`=8'hA5, 8'h3C, 8'hFF and `OutReady`=1 → three pops in order, `OutErr`=0, `ErrCount`=0.
- `OutReady`=0, six captures with `DEPTH`=4 → four entries held, `Overrun`=1, first four bytes drained in order. Then `ClearStatus` → `Overrun`=0.
- `CfgWrite` (baud 2'b11, parity 2'b01) issued with `RxLine`=0 → `CfgBusy` stays 1 and `BaudRate` is unchanged until 16 high cycles elapse, then both update and `CfgBusy`=0.
- Capture with `RxError`=1 and `RxData`=8'h55 → `ErrCount`=1; `OutErr`=1 with the macro undefined, and no entry with it defined.
- `ERR_CNT_W`=2, five errored captures → `ErrCount` stays at 3. `ClearStatus` coincident with an errored capture → `ErrCount`=1.
- Queue full, with push and pop in the same cycle → both succeed, `Overrun`=0. Then `Reset` asserted mid-stream → `OutValid`=0 asynchronously, pending configuration discarded.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: line FSM states, baud/parity encodings and queue entry type for rx_frame_ctrl
package rx_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, APPLY} lineState_t;
  localparam logic [1:0] BAUD_9600 = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_57600 = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  typedef struct packed {
    logic err;
    logic [7:0] data;
  } rxEntry_t;
endpackage

// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: valid/ready frame stream from rx_frame_ctrl to its consumer
interface rx_frame_ctrl_if;
  logic OutValid;
  logic OutReady;
  logic [7:0] OutData;
  logic OutErr;
  modport master(output OutValid, OutData, OutErr, input OutReady);
  modport slave(input OutValid, OutData, OutErr, output OutReady);
endinterface

// File: rtl/rx_ctrl_fifo.sv
// rx_ctrl_fifo: first-word-fall-through frame queue with extra-bit full/empty pointers
module rx_ctrl_fifo
  import rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     Clock,
  input  logic     Reset,
  input  logic     push,
  input  logic     pop,
  input  rxEntry_t pushEntry,
  output logic     full,
  output logic     empty,
  output rxEntry_t head
);
  localparam int AW = $clog2(DEPTH);
  rxEntry_t mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  assign empty = wrPtr == rdPtr;
  assign full = wrPtr[AW] != rdPtr[AW] && wrPtr[AW-1:0] == rdPtr[AW-1:0];
  assign head = empty ? '0 : mem[rdPtr[AW-1:0]];
  always_ff @(posedge Clock)
    if (push) mem[wrPtr[AW-1:0]] <= pushEntry;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= wrPtr + (AW+1)'(push);
      rdPtr <= rdPtr + (AW+1)'(pop);
    end
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART receive controller (idle-deferred config, frame queue, statistics)
// Define RXCTRL_ERR_DROP_EN to count but not queue errored frames.
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_CNT_W = 8,
  parameter int IDLE_CYCLES = 16,
  parameter logic [1:0] RST_BAUD = BAUD_9600,
  parameter logic [1:0] RST_PARITY = PARITY_NONE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxLine,
  input  logic                 RxDone,
  input  logic                 RxError,
  input  logic [7:0]           RxData,
  output logic [1:0]           BaudRate,
  output logic [1:0]           ParityType,
  input  logic                 CfgWrite,
  input  logic [1:0]           CfgBaud,
  input  logic [1:0]           CfgParity,
  output logic                 CfgBusy,
  rx_frame_ctrl_if.master      outIf,
  input  logic                 ClearStatus,
  output logic [ERR_CNT_W-1:0] ErrCount,
  output logic                 Overrun
);
  localparam int RUN_W = $clog2(IDLE_CYCLES + 1);
  lineState_t state, nextState;
  logic [RUN_W-1:0] runCnt;
  logic [1:0] pendBaud, pendParity;
  logic doneQ, capture, pushReq, push, pop, full, empty, errEv, applyCfg, lineQuiet;
  rxEntry_t head, pushEntry;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nextState;
  assign lineQuiet = RxLine && runCnt == RUN_W'(IDLE_CYCLES - 1);
  always_comb
    nextState = state == IDLE   ? (!RxLine ? ACTIVE : CfgBusy ? APPLY : IDLE) :
                state == ACTIVE ? (lineQuiet ? IDLE : ACTIVE) : IDLE;
  always_comb applyCfg = state == APPLY;
  // run counter only advances while ACTIVE, so it is zero on every ACTIVE entry
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) runCnt <= '0;
    else runCnt <= (state == ACTIVE && RxLine && !lineQuiet) ? runCnt + RUN_W'(1) : '0;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      pendBaud <= RST_BAUD;
      pendParity <= RST_PARITY;
      BaudRate <= RST_BAUD;
      ParityType <= RST_PARITY;
      CfgBusy <= 1'b0;
    end else begin
      if (CfgWrite) begin
        pendBaud <= CfgBaud;
        pendParity <= CfgParity;
      end
      if (applyCfg) begin
        BaudRate <= pendBaud;
        ParityType <= pendParity;
      end
      CfgBusy <= CfgWrite || (CfgBusy && !applyCfg);
    end
  assign capture = RxDone && !doneQ;
  assign errEv = capture && RxError;
`ifdef RXCTRL_ERR_DROP_EN
  assign pushReq = capture && !RxError;
  assign outIf.OutErr = 1'b0;
`else
  assign pushReq = capture;
  assign outIf.OutErr = head.err;
`endif
  assign pop = outIf.OutValid && outIf.OutReady;
  assign push = pushReq && (!full || pop);
  assign pushEntry = '{err: RxError, data: RxData};
  assign outIf.OutValid = !empty;
  assign outIf.OutData = head.data;
  // doneQ resets high so a level already present at reset exit is not an event
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      doneQ <= 1'b1;
      Overrun <= 1'b0;
      ErrCount <= '0;
    end else begin
      doneQ <= RxDone;
      Overrun <= (pushReq && full && !pop) || (Overrun && !ClearStatus);
      ErrCount <= ClearStatus ? ERR_CNT_W'(errEv) : ErrCount + ERR_CNT_W'(errEv && !(&ErrCount));
    end
  rx_ctrl_fifo #(.DEPTH(DEPTH)) fifo (
    .Clock(Clock),
    .Reset(Reset),
    .push(push),
    .pop(pop),
    .pushEntry(pushEntry),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
